// File: rtl/pkg_7seg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pkg_7seg : segment type, hex glyph constants and nibble decode function     |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+
package pkg_7seg;

    // Bit 0 is segment a, bit 6 is segment g; patterns are active high.
    typedef logic [0:6] seg_t;

    localparam seg_t SEG_0 = 7'b1111110;
    localparam seg_t SEG_1 = 7'b0110000;
    localparam seg_t SEG_2 = 7'b1101101;
    localparam seg_t SEG_3 = 7'b1111001;
    localparam seg_t SEG_4 = 7'b0110011;
    localparam seg_t SEG_5 = 7'b1011011;
    localparam seg_t SEG_6 = 7'b1011111;
    localparam seg_t SEG_7 = 7'b1110000;
    localparam seg_t SEG_8 = 7'b1111111;
    localparam seg_t SEG_9 = 7'b1111011;
    localparam seg_t SEG_A = 7'b1110111;
    localparam seg_t SEG_B = 7'b0011111;
    localparam seg_t SEG_C = 7'b1001110;
    localparam seg_t SEG_D = 7'b0111101;
    localparam seg_t SEG_E = 7'b1001111;
    localparam seg_t SEG_F = 7'b1000111;

    function automatic seg_t decode(input logic [3:0] nibble, input seg_t dflt);
        seg_t seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = dflt;  // X/Z nibble
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_7seg_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mod_7seg_dec : combinational hex nibble to active-high segment decoder      |
// | Rev 1.0      : initial release                                              |
// +----------------------------------------------------------------------------+
module mod_7seg_dec
    import pkg_7seg::*;
#(
    parameter seg_t DEFAULT_STATE = 7'b0000000
) (
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = decode(nibble, DEFAULT_STATE);

endmodule
`default_nettype wire

// File: rtl/mod_7seg_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mod_7seg_scan : multiplexed N-digit hex display driver with frame-aligned   |
// |                 word update, anti-ghost blanking and leading-zero suppress  |
// | Rev 1.0       : initial release                                             |
// +----------------------------------------------------------------------------+
module mod_7seg_scan
    import pkg_7seg::*;
#(
    parameter int   N_DIGITS      = 4,
    parameter int   SCAN_DIV      = 1024,
    parameter int   BLANK_CYCLES  = 16,
    parameter seg_t DEFAULT_STATE = 7'b0000000
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic                  i_lzs,
    input  logic                  i_valid,
    output logic                  o_ready,
    output seg_t                  o_segments,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_digit_en
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] C_PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] C_BLANK   = PW'(BLANK_CYCLES);
    localparam logic [DW-1:0] C_DIG_MAX = DW'(N_DIGITS - 1);

    logic [PW-1:0]           r_pre;
    logic [DW-1:0]           r_digit;
    logic                    r_pend;
    logic [4*N_DIGITS-1:0]   r_pend_value;
    logic [N_DIGITS-1:0]     r_pend_dp;
    logic                    r_pend_lzs;
    logic [4*N_DIGITS-1:0]   r_act_value;
    logic [N_DIGITS-1:0]     r_act_dp;
    logic                    r_act_lzs;
    seg_t                    r_seg;
    logic                    r_dp;
    logic [N_DIGITS-1:0]     r_en;

    logic                    w_wrap;
    logic                    w_fb;
    logic                    w_accept;
    logic                    w_blank;
    logic [N_DIGITS-1:0]     w_zero_from;
    logic [3:0]              w_nibble;
    logic                    w_dp_sel;
    logic                    w_suppress;
    logic [N_DIGITS-1:0]     w_digit_oh;
    seg_t                    w_dec;

    assign w_wrap   = (r_pre == C_PRE_MAX);
    assign w_fb     = w_wrap && (r_digit == C_DIG_MAX);
    assign w_accept = i_valid && !r_pend;
    assign o_ready  = !r_pend;

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign w_blank = (r_pre < C_BLANK);
        end else begin : g_no_blank
            assign w_blank = 1'b0;
        end
    endgenerate

    // w_zero_from[k]: nibbles k and above of the active word are all zero
    generate
        for (genvar k = 0; k < N_DIGITS; k++) begin : g_zero
            assign w_zero_from[k] = (r_act_value[4*N_DIGITS-1:4*k] == '0);
        end
    endgenerate

    always_comb begin
        w_nibble   = 4'h0;
        w_dp_sel   = 1'b0;
        w_suppress = 1'b0;
        w_digit_oh = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_digit == DW'(k)) begin
                w_nibble      = r_act_value[4*k +: 4];
                w_dp_sel      = r_act_dp[k];
                w_suppress    = (k != 0) && r_act_lzs && w_zero_from[k];
                w_digit_oh[k] = 1'b1;
            end
        end
    end

    mod_7seg_dec #(
        .DEFAULT_STATE (DEFAULT_STATE)
    ) u_dec (
        .nibble (w_nibble),
        .seg    (w_dec)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_pre   <= '0;
            r_digit <= '0;
        end else if (w_wrap) begin
            r_pre   <= '0;
            r_digit <= (r_digit == C_DIG_MAX) ? '0 : r_digit + 1'b1;
        end else begin
            r_pre   <= r_pre + 1'b1;
        end
    end

    // Accept and transfer are exclusive: accept needs pending clear, transfer needs it set,
    // so a word accepted on the frame boundary waits for the next one.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_pend       <= 1'b0;
            r_pend_value <= '0;
            r_pend_dp    <= '0;
            r_pend_lzs   <= 1'b0;
            r_act_value  <= '0;
            r_act_dp     <= '0;
            r_act_lzs    <= 1'b0;
        end else if (w_accept) begin
            r_pend       <= 1'b1;
            r_pend_value <= i_value;
            r_pend_dp    <= i_dp;
            r_pend_lzs   <= i_lzs;
        end else if (w_fb && r_pend) begin
            r_pend       <= 1'b0;
            r_act_value  <= r_pend_value;
            r_act_dp     <= r_pend_dp;
            r_act_lzs    <= r_pend_lzs;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_seg <= '1;
            r_dp  <= 1'b1;
            r_en  <= '1;
        end else begin
            r_seg <= (w_blank || w_suppress) ? '1 : ~w_dec;
            r_dp  <= w_blank ? 1'b1 : ~w_dp_sel;
            r_en  <= w_blank ? '1 : ~w_digit_oh;
        end
    end

    assign o_segments = r_seg;
    assign o_dp       = r_dp;
    assign o_digit_en = r_en;

endmodule
`default_nettype wire
